// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 32-bit result words in a FIFO and sends each as four 8N1 UART bytes, LSB first.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [31:0]   word_in,
  input  logic          word_valid,
  output logic          tx,
  output logic          busy,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [31:0]   shift_q;
  logic          tx_q, busy_q, ovf_q, pop, push, bit_end;
  assign pop     = state_q == IDLE && count_q != '0;
  assign push    = word_valid && (count_q != CW'(FIFO_DEPTH) || pop);
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  always_comb count_d = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= word_in;
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
      ovf_q   <= ovf_q | (word_valid & ~push);
    end
  // tx and busy are registered from the previous state, so the line lags the FSM by one cycle
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[bit_q] : 1'b1;
      busy_q <= state_q != IDLE || count_q != '0;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
      case (state_q)
        IDLE:
          if (pop) begin
            shift_q <= mem_q[rd_q];
            byte_q  <= '0;
            state_q <= START;
          end
        START:
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= DATA;
          end
        DATA:
          if (bit_end) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        STOP:
          if (bit_end) begin
            if (byte_q == 2'd3) state_q <= IDLE;
            else begin
              byte_q  <= byte_q + 2'd1;
              shift_q <= shift_q >> 8;
              state_q <= START;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;
endmodule
